// File: rtl/esdi_read_deserializer_pkg.sv
// Shared definitions for the ESDI read deserializer: FSM encoding,
// output beat layout and the terminator beat used for truncated frames.
package esdi_read_deserializer_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HUNT    = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_TERM    = 3'd3;
  localparam logic [2:0] ST_WAITLOW = 3'd4;

  localparam logic [7:0] SYNC_PATTERN = 8'h19;

  typedef struct packed {
    logic [7:0] tdata;
    logic       tlast;
    logic       tuser;
  } beat_t;

  // A truncated frame is closed with an all-zero byte flagged in tuser.
  localparam beat_t TERM_BEAT = '{tdata: 8'h00, tlast: 1'b1, tuser: 1'b1};

  function automatic logic [7:0] shift_in8(input logic [7:0] v, input logic b);
    return {v[6:0], b};
  endfunction

endpackage

// File: rtl/esdi_read_deserializer_if.sv
// Byte-wide AXI-Stream link from the deserializer to the capture/DMA path.
interface esdi_read_deserializer_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;
  logic       tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/esdi_read_deserializer_bit_sampler.sv
// Brings the drive's asynchronous read clock/data into the csr_aclk domain
// and flags one sample per rising read-clock edge. Shared with the write-path checker.
module esdi_bit_sampler (
  input  logic clk,
  input  logic rst,
  input  logic read_clock_i,
  input  logic read_data_i,
  output logic bit_valid_o,
  output logic bit_data_o
);

  // clk_q[1] is the synchronized clock, clk_q[2] its previous value
  logic [2:0] clk_q;
  logic [1:0] dat_q;

  // 2-FF synchronizers, plus a third clock flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_q <= '0;
      dat_q <= '0;
    end else begin
      clk_q <= {clk_q[1:0], read_clock_i};
      dat_q <= {dat_q[0], read_data_i};
    end
  end

  assign bit_valid_o = clk_q[1] & ~clk_q[2];
  assign bit_data_o  = dat_q[1];

endmodule

// File: rtl/esdi_read_deserializer.sv
// ESDI read deserializer: hunts for a sync pattern inside the read-gate
// window, packs the following bits MSB-first into bytes and streams each
// frame out over a one-entry AXI-Stream output register.
module esdi_read_deserializer
  import esdi_read_deserializer_pkg::*;
#(
  parameter int SYNC_WIDTH   = 8,
  parameter int SYNC_TIMEOUT = 4096,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                  csr_aclk,
  input  logic                  csr_areset,
  input  logic                  enable,
  input  logic [SYNC_WIDTH-1:0] sync_pattern,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  esdi_read_gate,
  input  logic                  esdi_read_clock,
  input  logic                  esdi_read_data,
  esdi_read_deserializer_if.master m_axis,
  output logic                  sync_found,
  output logic                  sync_timeout,
  output logic                  overrun,
  input  logic                  overrun_clear,
  output logic                  busy
);

  localparam int HW = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam logic [HW-1:0] HUNT_LAST = HW'(SYNC_TIMEOUT - 1);

  logic bit_valid, bit_data;

  esdi_bit_sampler u_sampler (
    .clk          (csr_aclk),
    .rst          (csr_areset),
    .read_clock_i (esdi_read_clock),
    .read_data_i  (esdi_read_data),
    .bit_valid_o  (bit_valid),
    .bit_data_o   (bit_data)
  );

  logic [2:0]            state_q, state_d;
  logic [SYNC_WIDTH-1:0] sr_q, sr_d, sr_next;
  logic [HW-1:0]         hunt_q, hunt_d;
  logic [2:0]            bit_q, bit_d;
  logic [LEN_WIDTH-1:0]  byte_q, byte_d, last_idx;
  logic [7:0]            pack_q, pack_d, pack_next;
  beat_t                 out_q, out_d;
  logic                  tvalid_q, tvalid_d;
  logic                  found_q, found_d;
  logic                  tmo_q, tmo_d;
  logic                  ovr_q, ovr_d, ovr_set;
  logic                  free, is_last;

  assign free      = !tvalid_q || m_axis.tready;
  assign sr_next   = {sr_q[SYNC_WIDTH-2:0], bit_data};
  assign pack_next = shift_in8(pack_q, bit_data);
  // A zero length still yields a one-byte frame
  assign last_idx  = (frame_len == '0) ? '0 : frame_len - LEN_WIDTH'(1);
  assign is_last   = (byte_q == last_idx);

  // Next-state: FSM, bit/byte packing and output register load/drain
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    hunt_d   = hunt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    pack_d   = pack_q;
    out_d    = out_q;
    tvalid_d = tvalid_q;
    found_d  = 1'b0;
    tmo_d    = 1'b0;
    ovr_set  = 1'b0;

    if (tvalid_q && m_axis.tready) tvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && esdi_read_gate) begin
          state_d = ST_HUNT;
          sr_d    = '0;
          hunt_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          pack_d  = '0;
        end
      end
      ST_HUNT: begin
        if (!esdi_read_gate) begin
          state_d = ST_IDLE;
        end else if (bit_valid) begin
          sr_d = sr_next;
          if (sr_next == sync_pattern) begin
            found_d = 1'b1;
            state_d = ST_DATA;
          end else if (hunt_q == HUNT_LAST) begin
            tmo_d   = 1'b1;
            state_d = ST_WAITLOW;
          end else begin
            hunt_d = hunt_q + HW'(1);
          end
        end
      end
      ST_DATA: begin
        if (!esdi_read_gate) begin
          // Partial byte is discarded; only a frame that already emitted data gets a terminator
          state_d = (byte_q != '0) ? ST_TERM : ST_IDLE;
        end else if (bit_valid) begin
          pack_d = pack_next;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            byte_d = byte_q + LEN_WIDTH'(1);
            if (free) begin
              out_d    = '{tdata: pack_next, tlast: is_last, tuser: 1'b0};
              tvalid_d = 1'b1;
            end else begin
              ovr_set = 1'b1;
            end
            // A lost tlast byte must still close the frame, so fall back to a terminator
            if (is_last) state_d = free ? ST_WAITLOW : ST_TERM;
          end
        end
      end
      ST_TERM: begin
        if (free) begin
          out_d    = TERM_BEAT;
          tvalid_d = 1'b1;
          state_d  = ST_WAITLOW;
        end
      end
      ST_WAITLOW: begin
        if (!esdi_read_gate) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) state_d = ST_IDLE;

    ovr_d = ovr_set ? 1'b1 : (overrun_clear ? 1'b0 : ovr_q);
  end

  // State and datapath registers
  always_ff @(posedge csr_aclk or posedge csr_areset) begin
    if (csr_areset) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      hunt_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      pack_q   <= '0;
      out_q    <= '0;
      tvalid_q <= 1'b0;
      found_q  <= 1'b0;
      tmo_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      hunt_q   <= hunt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      pack_q   <= pack_d;
      out_q    <= out_d;
      tvalid_q <= tvalid_d;
      found_q  <= found_d;
      tmo_q    <= tmo_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = out_q.tdata;
  assign m_axis.tlast  = out_q.tlast;
  assign m_axis.tuser  = out_q.tuser;
  assign sync_found    = found_q;
  assign sync_timeout  = tmo_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_esdi_read_deserializer.sv
// Directed bench for the ESDI read deserializer: table of frame vectors
// plus hand sequences for backpressure/overrun, hunt timeout and reset.
module tb_esdi_read_deserializer;

  localparam int TMO = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        gate = 1'b0;
  logic        rclk = 1'b0;
  logic        rdat = 1'b0;
  logic        oclr = 1'b0;
  logic [7:0]  pat = 8'h19;
  logic [15:0] flen = 16'd4;
  logic        sync_found, sync_timeout, overrun, busy;

  esdi_read_deserializer_if axis ();

  esdi_read_deserializer #(.SYNC_WIDTH(8), .SYNC_TIMEOUT(TMO), .LEN_WIDTH(16)) dut (
    .csr_aclk        (clk),
    .csr_areset      (rst),
    .enable          (enable),
    .sync_pattern    (pat),
    .frame_len       (flen),
    .esdi_read_gate  (gate),
    .esdi_read_clock (rclk),
    .esdi_read_data  (rdat),
    .m_axis          (axis),
    .sync_found      (sync_found),
    .sync_timeout    (sync_timeout),
    .overrun         (overrun),
    .overrun_clear   (oclr),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic hold_chk = 1'b0;
  logic [7:0] hold_data = 8'h00;

  // Monitor: accepted beats and pulse counts
  logic [9:0] beats[$];
  int nfound = 0;
  int ntmo = 0;
  always @(negedge clk) begin
    if (axis.tvalid && axis.tready) beats.push_back({axis.tdata, axis.tlast, axis.tuser});
    if (sync_found) nfound <= nfound + 1;
    if (sync_timeout) ntmo <= ntmo + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit cell: data set with clock low, sampled on the rising edge
  task automatic send_bit(input logic b);
    rdat = b;
    rclk = 1'b0;
    cyc(4);
    if (hold_chk) begin
      check("hold_tvalid", {31'd0, axis.tvalid}, 32'd1);
      check("hold_tdata", {24'd0, axis.tdata}, {24'd0, hold_data});
    end
    rclk = 1'b1;
    cyc(4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 32; i++) send_bit(1'b0);
    send_byte(8'h19);
  endtask

  typedef struct packed {
    logic [15:0] flen;
    logic [3:0]  nbytes;
    logic [63:0] bytes;
    logic [2:0]  nx;
    logic [4:0]  xbits;
    logic [2:0]  exp_n;
    logic [31:0] exp_data;
    logic [3:0]  exp_last;
    logic [3:0]  exp_user;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int b0, f0, n;
    logic [9:0] exp_b;
    b0 = beats.size();
    f0 = nfound;
    flen = v.flen;
    gate = 1'b1;
    cyc(4);
    send_preamble();
    for (int i = 0; i < int'(v.nbytes); i++) send_byte(v.bytes[63-8*i -: 8]);
    for (int i = 0; i < int'(v.nx); i++) send_bit(v.xbits[4-i]);
    cyc(4);
    gate = 1'b0;
    cyc(20);
    n = beats.size() - b0;
    check("beat_count", n, {29'd0, v.exp_n});
    for (int i = 0; i < int'(v.exp_n); i++) begin
      exp_b = {v.exp_data[31-8*i -: 8], v.exp_last[i], v.exp_user[i]};
      if (i < n) check("beat", {22'd0, beats[b0+i]}, {22'd0, exp_b});
    end
    check("sync_found_cnt", nfound - f0, 32'd1);
    check("busy_after_gate", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int b0, f0, t0;
    logic [7:0] win;
    logic b;

    vecs[0] = '{16'd4, 4'd4, 64'hA53CFF01_00000000, 3'd0, 5'b00000, 3'd4, 32'hA53CFF01, 4'b1000, 4'b0000};
    vecs[1] = '{16'd8, 4'd3, 64'h112233_0000000000, 3'd5, 5'b10110, 3'd4, 32'h11223300, 4'b1000, 4'b1000};
    vecs[2] = '{16'd0, 4'd1, 64'h7E_00000000000000, 3'd0, 5'b00000, 3'd1, 32'h7E000000, 4'b0001, 4'b0000};
    vecs[3] = '{16'd1, 4'd2, 64'h5AC3_000000000000, 3'd0, 5'b00000, 3'd1, 32'h5A000000, 4'b0001, 4'b0000};
    vecs[4] = '{16'd8, 4'd0, 64'h0, 3'd5, 5'b10110, 3'd0, 32'h0, 4'b0000, 4'b0000};

    axis.tready = 1'b1;
    cyc(3);
    check("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_pulses", {30'd0, sync_found, sync_timeout}, 32'd0);
    rst = 1'b0;
    cyc(3);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Backpressure: A5 held, 3C dropped, overrun sticky until cleared
    b0 = beats.size();
    flen = 16'd4;
    gate = 1'b1;
    cyc(4);
    send_preamble();
    axis.tready = 1'b0;
    send_byte(8'hA5);
    hold_data = 8'hA5;
    hold_chk = 1'b1;
    send_byte(8'h3C);
    hold_chk = 1'b0;
    check("overrun_set", {31'd0, overrun}, 32'd1);
    axis.tready = 1'b1;
    send_byte(8'hFF);
    send_byte(8'h01);
    cyc(4);
    gate = 1'b0;
    cyc(20);
    check("ovr_beat_count", beats.size() - b0, 32'd3);
    if (beats.size() - b0 == 3) begin
      check("ovr_beat0", {22'd0, beats[b0]},   {22'd0, 8'hA5, 2'b00});
      check("ovr_beat1", {22'd0, beats[b0+1]}, {22'd0, 8'hFF, 2'b00});
      check("ovr_beat2", {22'd0, beats[b0+2]}, {22'd0, 8'h01, 2'b10});
    end
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    oclr = 1'b1;
    cyc(1);
    oclr = 1'b0;
    cyc(1);
    check("overrun_cleared", {31'd0, overrun}, 32'd0);

    // Hunt timeout: TMO bits that never form the pattern
    b0 = beats.size();
    f0 = nfound;
    t0 = ntmo;
    gate = 1'b1;
    cyc(4);
    win = 8'h00;
    for (int i = 0; i < TMO; i++) begin
      b = 1'($urandom_range(1, 0));
      if ({win[6:0], b} == 8'h19) b = ~b;
      win = {win[6:0], b};
      send_bit(b);
      if (i == TMO - 2) check("no_early_timeout", ntmo - t0, 32'd0);
    end
    cyc(4);
    check("timeout_pulse", ntmo - t0, 32'd1);
    check("timeout_no_sync", nfound - f0, 32'd0);
    check("timeout_no_beats", beats.size() - b0, 32'd0);
    check("timeout_busy", {31'd0, busy}, 32'd1);
    gate = 1'b0;
    cyc(4);
    check("timeout_idle", {31'd0, busy}, 32'd0);

    // Reset mid-frame with a beat pending
    flen = 16'd4;
    gate = 1'b1;
    axis.tready = 1'b0;
    cyc(4);
    send_preamble();
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    check("pre_rst_tvalid", {31'd0, axis.tvalid}, 32'd1);
    rst = 1'b1;
    cyc(1);
    check("rst_mid_tvalid", {31'd0, axis.tvalid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    gate = 1'b0;
    axis.tready = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
